// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage controller for the LC-3b load/store opcodes LDR, LDB, LDI,
// STR, STB and STI. It runs one data-memory transaction, or two for the
// indirect forms, over a request/response handshake. It stalls upstream
// stages while the access is pending. It returns load data aligned for
// write-back. Other opcodes pass through with no effect.
//
// Ports
//   clk              in   clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   valid_in         in   MEM stage holds a valid instruction
//   opcode           in   4-bit LC-3b opcode
//   addr             in   effective address from the ALU
//   store_data       in   SR value for stores
//   dmem_read        out  read request, held until dmem_resp
//   dmem_write       out  write request, held until dmem_resp
//   dmem_address     out  transaction address
//   dmem_wdata       out  write data
//   dmem_byte_enable out  [1]=high byte, [0]=low byte
//   dmem_rdata       in   read data, valid with dmem_resp
//   dmem_resp        in   one-cycle transaction complete
//   load_data        out  registered write-back value
//   stall            out  freeze upstream stages
//   done             out  one-cycle pulse, access complete
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | waiting for a memory op; no request issued
// PTR   | indirect pointer read (LDI/STI)
// ACC   | final data access (read for loads, write for stores)
// DONE  | one-cycle completion pulse, no request issued

module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] load_data,
    output logic        stall,
    output logic        done
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [3:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] sdata_q;

    logic in_mem, in_ind;
    logic q_load, q_byte;
    logic accept;

    always_comb begin
        in_mem = (opcode == OP_LDR) || (opcode == OP_LDB) || (opcode == OP_LDI) ||
                 (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
        in_ind = (opcode == OP_LDI) || (opcode == OP_STI);
        q_load = (op_q == OP_LDR) || (op_q == OP_LDB) || (op_q == OP_LDI);
        q_byte = (op_q == OP_LDB) || (op_q == OP_STB);
    end

    assign accept = (state == IDLE) && valid_in && in_mem;

    // Gated by reset_n so the pipeline is never frozen while the block is held in reset.
    assign stall = reset_n && valid_in && in_mem && (state != DONE);

    always_comb begin
        state_n          = state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = in_ind ? PTR : ACC;
            end
            PTR: begin
                dmem_read        = 1'b1;
                dmem_address     = {addr_q[15:1], 1'b0};
                dmem_byte_enable = 2'b11;
                if (dmem_resp)
                    state_n = ACC;
            end
            ACC: begin
                dmem_read  = q_load;
                dmem_write = !q_load;
                if (q_byte) begin
                    dmem_address     = addr_q;
                    dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    dmem_wdata       = {sdata_q[7:0], sdata_q[7:0]};
                end else begin
                    dmem_address     = {addr_q[15:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = sdata_q;
                end
                if (dmem_resp)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= 4'h0;
            addr_q    <= 16'h0000;
            sdata_q   <= 16'h0000;
            load_data <= 16'h0000;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q    <= opcode;
                addr_q  <= addr;
                sdata_q <= store_data;
            end
            // The pointer read replaces the working address for the final access.
            if (state == PTR && dmem_resp)
                addr_q <= dmem_rdata;
            if (state == ACC && dmem_resp && q_load) begin
                if (q_byte)
                    load_data <= {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
                else
                    load_data <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] load_data;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Observations recorded by run_op for one operation.
    int          r_txn_cnt, r_rd_cyc, r_wr_cyc, r_done_cnt, r_done_cyc;
    logic        r_overlap, r_unstable, r_timeout, r_stall_acc, r_stall_done, r_req_in_done;
    logic [15:0] r_load;
    logic [15:0] r_addr  [2];
    logic [15:0] r_wdata [2];
    logic [1:0]  r_be    [2];
    logic        r_is_wr [2];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .opcode           (opcode),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .load_data        (load_data),
        .stall            (stall),
        .done             (done)
    );

    // Presents one op in the cycle after the call, acts as memory with
    // `waits` wait cycles per transaction, and records what it sees.
    // Address and store data are scrambled after acceptance so that the
    // DUT must be working from its latched copies.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                          input logic [15:0] pdata, input logic [15:0] rdata, input int waits);
        int age;
        int txn;
        bit fin;
        r_txn_cnt = 0; r_rd_cyc = 0; r_wr_cyc = 0; r_done_cnt = 0; r_done_cyc = 0;
        r_overlap = 0; r_unstable = 0; r_timeout = 0; r_stall_acc = 0; r_stall_done = 0;
        r_req_in_done = 0; r_load = 16'h0;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = 16'h0; r_wdata[i] = 16'h0; r_be[i] = 2'b00; r_is_wr[i] = 1'b0;
        end
        @(posedge clk); #1;
        valid_in = 1'b1; opcode = op; addr = a; store_data = sd; dmem_resp = 1'b0;
        #1 r_stall_acc = stall;
        age = 0; txn = 0; fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = 16'hDEAD;
            if (c == 0) begin
                addr = ~a; store_data = ~sd;
            end
            if (dmem_read && dmem_write) r_overlap = 1'b1;
            if (done) begin
                r_done_cnt++;
                r_done_cyc    = c + 1;
                r_load        = load_data;
                r_stall_done  = stall;
                r_req_in_done = dmem_read | dmem_write;
                valid_in = 1'b0; opcode = OP_ADD;
                fin = 1;
            end else if (dmem_read || dmem_write) begin
                if (dmem_read) r_rd_cyc++; else r_wr_cyc++;
                if (txn < 2) begin
                    if (age == 0) begin
                        r_addr[txn] = dmem_address; r_wdata[txn] = dmem_wdata;
                        r_be[txn] = dmem_byte_enable; r_is_wr[txn] = dmem_write;
                    end else if (r_addr[txn] !== dmem_address || r_wdata[txn] !== dmem_wdata ||
                                 r_be[txn] !== dmem_byte_enable || r_is_wr[txn] !== dmem_write) begin
                        r_unstable = 1'b1;
                    end
                end
                if (age == waits) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = (txn == 0 && (op == OP_LDI || op == OP_STI)) ? pdata : rdata;
                    age = 0;
                    txn++;
                end else begin
                    age++;
                end
            end
        end
        r_txn_cnt = txn;
        r_timeout = !fin;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; valid_in = 1'b1; opcode = OP_LDR; addr = 16'h1235;
        store_data = 16'h9999; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        #7;
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, load_data, done} !== 52'h0) begin
            errors++;
            $display("FAIL reset_outputs rd=%b wr=%b addr=%h wdata=%h be=%b ld=%h done=%b required all zero",
                     dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, load_data, done);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b required 0", stall);
        end
        valid_in = 1'b0; opcode = OP_ADD;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_ldr();
        run_op(OP_LDR, 16'h3005, 16'h0, 16'h0, 16'hBEEF, 2);
        checks++;
        if (r_timeout !== 1'b0) begin errors++; $display("FAIL ldr_timeout got done_cnt=%0d required 1", r_done_cnt); end
        checks++;
        if (r_stall_acc !== 1'b1) begin errors++; $display("FAIL ldr_stall_accept got %b required 1", r_stall_acc); end
        checks++;
        if ({r_addr[0], r_be[0], r_is_wr[0]} !== {16'h3004, 2'b11, 1'b0})
            begin errors++; $display("FAIL ldr_request got addr=%h be=%b wr=%b required 3004 11 0", r_addr[0], r_be[0], r_is_wr[0]); end
        checks++;
        if (r_rd_cyc !== 3 || r_wr_cyc !== 0 || r_unstable !== 1'b0)
            begin errors++; $display("FAIL ldr_hold got rd=%0d wr=%0d unstable=%b required 3 0 0", r_rd_cyc, r_wr_cyc, r_unstable); end
        checks++;
        if (r_done_cyc !== 4 || r_done_cnt !== 1)
            begin errors++; $display("FAIL ldr_latency got cyc=%0d cnt=%0d required 4 1", r_done_cyc, r_done_cnt); end
        checks++;
        if (r_load !== 16'hBEEF) begin errors++; $display("FAIL ldr_load_data got %h required beef", r_load); end
        checks++;
        if (r_stall_done !== 1'b0) begin errors++; $display("FAIL ldr_stall_done got %b required 0", r_stall_done); end
        @(posedge clk); #1;
        checks++;
        if ({done, stall, dmem_read, dmem_write} !== 4'b0000)
            begin errors++; $display("FAIL ldr_after got done=%b stall=%b rd=%b wr=%b required 0000", done, stall, dmem_read, dmem_write); end
    endtask

    task automatic test_ldb();
        run_op(OP_LDB, 16'h4001, 16'h0, 16'h0, 16'h12AB, 0);
        checks++;
        if ({r_addr[0], r_be[0], r_load} !== {16'h4001, 2'b10, 16'h0012} || r_done_cyc !== 2 || r_timeout)
            begin errors++; $display("FAIL ldb_high got addr=%h be=%b ld=%h cyc=%0d required 4001 10 0012 2", r_addr[0], r_be[0], r_load, r_done_cyc); end
        run_op(OP_LDB, 16'h4000, 16'h0, 16'h0, 16'h12AB, 0);
        checks++;
        if ({r_addr[0], r_be[0], r_load} !== {16'h4000, 2'b01, 16'h00AB} || r_timeout)
            begin errors++; $display("FAIL ldb_low got addr=%h be=%b ld=%h required 4000 01 00ab", r_addr[0], r_be[0], r_load); end
    endtask

    task automatic test_stb();
        run_op(OP_STB, 16'h5001, 16'h00C3, 16'h0, 16'hFFFF, 1);
        checks++;
        if ({r_addr[0], r_be[0], r_wdata[0], r_is_wr[0]} !== {16'h5001, 2'b10, 16'hC3C3, 1'b1} || r_timeout)
            begin errors++; $display("FAIL stb_request got addr=%h be=%b wdata=%h wr=%b required 5001 10 c3c3 1", r_addr[0], r_be[0], r_wdata[0], r_is_wr[0]); end
        checks++;
        if (r_rd_cyc !== 0 || r_wr_cyc !== 2 || r_unstable)
            begin errors++; $display("FAIL stb_no_read got rd=%0d wr=%0d unstable=%b required 0 2 0", r_rd_cyc, r_wr_cyc, r_unstable); end
        checks++;
        if (r_load !== 16'h00AB || r_done_cnt !== 1)
            begin errors++; $display("FAIL stb_load_kept got ld=%h done=%0d required 00ab 1", r_load, r_done_cnt); end
    endtask

    task automatic test_sti();
        run_op(OP_STI, 16'h6000, 16'h55AA, 16'h7002, 16'hFFFF, 1);
        checks++;
        if ({r_addr[0], r_be[0], r_is_wr[0]} !== {16'h6000, 2'b11, 1'b0} || r_timeout)
            begin errors++; $display("FAIL sti_ptr got addr=%h be=%b wr=%b required 6000 11 0", r_addr[0], r_be[0], r_is_wr[0]); end
        checks++;
        if ({r_addr[1], r_be[1], r_wdata[1], r_is_wr[1]} !== {16'h7002, 2'b11, 16'h55AA, 1'b1})
            begin errors++; $display("FAIL sti_write got addr=%h be=%b wdata=%h wr=%b required 7002 11 55aa 1", r_addr[1], r_be[1], r_wdata[1], r_is_wr[1]); end
        checks++;
        if (r_txn_cnt !== 2 || r_done_cnt !== 1 || r_done_cyc !== 5 || r_load !== 16'h00AB || r_overlap)
            begin errors++; $display("FAIL sti_done got txn=%0d done=%0d cyc=%0d ld=%h ovl=%b required 2 1 5 00ab 0", r_txn_cnt, r_done_cnt, r_done_cyc, r_load, r_overlap); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(posedge clk); #1;
        valid_in = 1'b1; opcode = OP_LDI; addr = 16'h8001; store_data = 16'h0;
        @(posedge clk); #1;
        checks++;
        if ({dmem_read, dmem_address} !== {1'b1, 16'h8000})
            begin errors++; $display("FAIL rst_mid_ptr got rd=%b addr=%h required 1 8000", dmem_read, dmem_address); end
        dmem_resp = 1'b1; dmem_rdata = 16'h9003;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = 16'hDEAD;
        checks++;
        if ({dmem_read, dmem_address} !== {1'b1, 16'h9002})
            begin errors++; $display("FAIL rst_mid_acc got rd=%b addr=%h required 1 9002", dmem_read, dmem_address); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, load_data, done, stall} !== 53'h0)
            begin errors++; $display("FAIL rst_mid_zero got rd=%b wr=%b addr=%h ld=%h stall=%b required all zero", dmem_read, dmem_write, dmem_address, load_data, stall); end
        valid_in = 1'b0; opcode = OP_ADD;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1 dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 dmem_resp = 1'b0;
            if (done || dmem_read || dmem_write || load_data !== 16'h0) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got activity=%b required 0", bad); end
        run_op(OP_LDR, 16'h3011, 16'h0, 16'h0, 16'h1234, 1);
        checks++;
        if ({r_addr[0], r_load} !== {16'h3010, 16'h1234} || r_done_cnt !== 1 || r_done_cyc !== 3 || r_timeout)
            begin errors++; $display("FAIL rst_mid_next got addr=%h ld=%h done=%0d cyc=%0d required 3010 1234 1 3", r_addr[0], r_load, r_done_cnt, r_done_cyc); end
    endtask

    task automatic test_nonmem();
        logic [3:0] ops [2];
        bit bad;
        ops[0] = OP_ADD; ops[1] = OP_BR;
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            @(posedge clk); #1;
            valid_in = 1'b1; opcode = ops[k]; addr = 16'h2223; store_data = 16'h4444;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1 dmem_resp = 1'b1; dmem_rdata = 16'h7777;
                #1 if (dmem_read || dmem_write || stall || done) bad = 1;
            end
            dmem_resp = 1'b0; valid_in = 1'b0;
            checks++;
            if (bad !== 1'b0 || load_data !== 16'h1234)
                begin errors++; $display("FAIL nonmem_op%0d got activity=%b ld=%h required 0 1234", k, bad, load_data); end
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_LDR, 16'h2000, 16'h0, 16'h0, 16'hAAAA, 0);
        checks++;
        if ({r_load, r_req_in_done, r_overlap} !== {16'hAAAA, 1'b0, 1'b0} || r_done_cnt !== 1 || r_timeout)
            begin errors++; $display("FAIL b2b_ldr got ld=%h req_in_done=%b ovl=%b done=%0d required aaaa 0 0 1", r_load, r_req_in_done, r_overlap, r_done_cnt); end
        run_op(OP_STR, 16'h2101, 16'h5A5A, 16'h0, 16'hFFFF, 1);
        checks++;
        if ({r_addr[0], r_be[0], r_wdata[0], r_is_wr[0]} !== {16'h2100, 2'b11, 16'h5A5A, 1'b1} || r_rd_cyc !== 0 || r_timeout)
            begin errors++; $display("FAIL b2b_str got addr=%h be=%b wdata=%h wr=%b rd=%0d required 2100 11 5a5a 1 0", r_addr[0], r_be[0], r_wdata[0], r_is_wr[0], r_rd_cyc); end
        checks++;
        if (r_load !== 16'hAAAA || r_done_cnt !== 1 || r_done_cyc !== 3 || r_txn_cnt !== 1)
            begin errors++; $display("FAIL b2b_str_done got ld=%h done=%0d cyc=%0d txn=%0d required aaaa 1 3 1", r_load, r_done_cnt, r_done_cyc, r_txn_cnt); end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_ldb();
        test_stb();
        test_sti();
        test_reset_mid();
        test_nonmem();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
